reg_digit_reader: RTL and testbench

//  Read-side counterpart of the enable-gated storage registers in the ATM datapath.
//  - On a start pulse, snapshots a stored N-digit BCD word (balance, amount or PIN).
//  - Streams the word out one digit per valid/ready handshake, most significant digit first.
//  - Feeds the display/receipt formatter.
//  - Flags leading-zero digits so the consumer can blank them.

---
 rtl/reg_digit_reader_pkg.sv | 5 +
 rtl/reg_digit_reader_digit_shift_reg.sv | 22 ++
 rtl/reg_digit_reader.sv | 76 +++++++
 tb/tb_reg_digit_reader.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/reg_digit_reader_pkg.sv
// reg_digit_reader_pkg: shared FSM state encoding and BCD digit width for the ATM digit reader
package reg_digit_reader_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_DONE = 2'd2} state_e;
  localparam int BCD_W = 4;
endpackage

// File: rtl/reg_digit_reader_digit_shift_reg.sv
// digit_shift_reg: load/shift-left-by-one-digit word register; ports clk, rst, load_i, shift_i, data_i -> top_o (MS digit), next_o (digit below it)
module digit_shift_reg
  import reg_digit_reader_pkg::*;
#(
  parameter  int DIGITS  = 4,
  parameter  int DIGIT_W = BCD_W,
  localparam int WIDTH   = DIGITS * DIGIT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic [DIGIT_W-1:0] top_o,
  output logic [DIGIT_W-1:0] next_o
);
  logic [WIDTH-1:0] word_q;
  always_ff @(posedge clk)
    word_q <= rst ? '0 : load_i ? data_i : shift_i ? {word_q[WIDTH-DIGIT_W-1:0], {DIGIT_W{1'b0}}} : word_q;
  assign top_o  = word_q[WIDTH-1 -: DIGIT_W];
  assign next_o = word_q[WIDTH-DIGIT_W-1 -: DIGIT_W];
endmodule

// File: rtl/reg_digit_reader.sv
// reg_digit_reader: snapshots a BCD word on start and streams it MS digit first over valid/ready with leading-zero blank flags; ports clk, rst, start, abort, data_in, dout_ready -> busy, dout_valid, dout, dout_idx, dout_blank, done
module reg_digit_reader
  import reg_digit_reader_pkg::*;
#(
  parameter  int DIGITS  = 4,
  parameter  int DIGIT_W = BCD_W,
  localparam int WIDTH   = DIGITS * DIGIT_W,
  localparam int IDX_W   = $clog2(DIGITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [DIGIT_W-1:0] dout,
  output logic [IDX_W-1:0]   dout_idx,
  output logic               dout_blank,
  output logic               done
);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_d;
  logic               lz_q, lz_d, valid_d, busy_d, done_d, blank_d;
  logic               load, hs, last, lz_next;
  logic [DIGIT_W-1:0] next_digit;
  assign load    = state_q == ST_IDLE && start;
  assign hs      = state_q == ST_SEND && dout_valid && dout_ready && !abort;
  assign last    = dout_idx == '0;
  assign lz_next = lz_q && dout == '0;
  digit_shift_reg #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .shift_i(hs),
    .data_i (data_in),
    .top_o  (dout),
    .next_o (next_digit)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dout_idx   <= '0;
      lz_q       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dout_blank <= 1'b0;
    end else begin
      state_q    <= state_d;
      dout_idx   <= idx_d;
      lz_q       <= lz_d;
      dout_valid <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
      dout_blank <= blank_d;
    end
  end
  always_comb
    state_d = state_q == ST_IDLE ? (start ? ST_SEND : ST_IDLE)
            : state_q == ST_SEND ? (abort ? ST_IDLE : hs && last ? ST_DONE : ST_SEND)
            : ST_IDLE;
  // blank flag is precomputed for the digit that will be on dout next cycle
  always_comb begin
    idx_d   = load ? IDX_W'(DIGITS - 1) : hs && !last ? dout_idx - 1'b1 : dout_idx;
    lz_d    = load ? 1'b1 : hs ? lz_next : lz_q;
    valid_d = state_d == ST_SEND;
    busy_d  = state_d != ST_IDLE;
    done_d  = state_d == ST_DONE;
    blank_d = load ? data_in[WIDTH-1 -: DIGIT_W] == '0
            : state_d != ST_SEND ? 1'b0
            : hs ? lz_next && next_digit == '0 && idx_d != '0
            : dout_blank;
  end
endmodule

// File: tb/tb_reg_digit_reader.sv
// tb_reg_digit_reader: scoreboard bench for reg_digit_reader with directed and randomized readouts
module tb_reg_digit_reader;
  logic        clk = 0, rst, start, abort, dout_ready, busy, dout_valid, dout_blank, done;
  logic [15:0] data_in;
  logic [3:0]  dout;
  logic [1:0]  dout_idx;
  int          errors = 0, checks = 0;
  typedef struct packed {logic [3:0] d; logic [1:0] i; logic b;} exp_t;
  exp_t        q[$];
  bit          done_due = 0;

  reg_digit_reader #(.DIGITS(4), .DIGIT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .data_in   (data_in),
    .busy      (busy),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_idx  (dout_idx),
    .dout_blank(dout_blank),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: digit i blank iff it and everything above it is zero, and it is not the last digit
  task automatic push_expected(input logic [15:0] d);
    exp_t e;
    for (int i = 3; i >= 0; i--) begin
      e.d = d[i*4 +: 4];
      e.i = 2'(i);
      e.b = ((d >> (i * 4)) == 16'h0) && i != 0;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst) done_due = 0;
    else begin
      if (done || done_due) chk("done_pulse", done, done_due);
      if (done) chk("busy_in_done", busy, 1);
      done_due = 0;
      if (dout_valid && !abort) begin
        if (q.size() == 0) chk("valid_without_expected", 1, 0);
        else begin
          chk("dout", dout, q[0].d);
          chk("dout_idx", dout_idx, q[0].i);
          chk("dout_blank", dout_blank, q[0].b);
          if (dout_ready) begin
            if (q[0].i == 0) done_due = 1;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // mode 0: ready always 1; mode 1: ready low for the first 3 valid cycles; mode 2: random
  // cut >= 0: after that many handshakes, assert rst (use_rst) or abort for one cycle
  task automatic run(input logic [15:0] d, input int mode, input int cut, input bit use_rst, input bit restart);
    int hs = 0, cyc = 0;
    bit cut_now = 0;
    @(posedge clk); #1;
    start = 1; data_in = d;
    push_expected(d);
    @(posedge clk); #1;
    start = 0; data_in = 16'($urandom);
    chk("first_valid_latency", dout_valid, 1);
    while (busy && cyc < 200) begin
      dout_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc >= 3) : 1'($urandom_range(0, 1));
      if (restart && cyc == 1) begin start = 1; data_in = 16'h9999; end
      else start = 0;
      if (cut >= 0 && hs == cut) begin
        cut_now = 1;
        q.delete();
        if (use_rst) rst = 1; else abort = 1;
      end else if (dout_valid && dout_ready) hs++;
      @(posedge clk); #1;
      cyc++;
      if (cut_now) begin
        rst = 0; abort = 0;
        chk("cut_valid", dout_valid, 0);
        chk("cut_busy", busy, 0);
        break;
      end
    end
    chk("readout_finished", busy, 0);
    chk("queue_drained", q.size(), 0);
    q.delete();
    start = 0; dout_ready = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    rst = 1; start = 0; abort = 0; dout_ready = 0; data_in = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_blank", dout_blank, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_idx", dout_idx, 0);
    rst = 0;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_idle_busy", busy, 0);
    run(16'h1234, 0, -1, 0, 0);
    run(16'h5678, 1, -1, 0, 0);
    run(16'h0050, 0, -1, 0, 0);
    run(16'h0000, 0, -1, 0, 0);
    run(16'h2468, 0, -1, 0, 1);
    run(16'h1234, 0, 2, 1, 0);
    run(16'h1234, 0, 2, 0, 0);
    run(16'h1234, 0, -1, 0, 0);
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++)
        w[k*4 +: 4] = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 9));
      run(w, 2, $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 3)) : -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
